// File: rtl/neural_stage_float2fix_pkg.sv
// Shared types for the float-to-fixed stage: operand layout, exponent bias and flush threshold.
package neural_stage_float2fix_pkg;

    typedef struct packed {
        logic        sgn;
        logic [7:0]  exp;
        logic [22:0] man;
    } float_24_8;

    localparam logic [7:0] EXP_BIAS  = 8'd127;
    localparam logic [7:0] FLUSH_EXP = 8'd10;

endpackage

// File: rtl/neural_stage_float2fix_if.sv
// Operand/result stream bundle; master drives operands and result-ready, slave is the converter.
interface neural_stage_float2fix_if
    import neural_stage_float2fix_pkg::*;
#(
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    float_24_8            in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/neural_stage_float2fix_round.sv
// Round-to-nearest-even, negate and clamp of a pre-shifted magnitude; purely combinational.
module neural_stage_float2fix_round
    import neural_stage_float2fix_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int MW        = OUT_WIDTH + 25
) (
    input  logic                 i_sgn,
    input  logic                 i_flush,
    input  logic                 i_ovf,
    input  logic [MW-1:0]        i_mag,
    input  logic                 i_grd,
    input  logic                 i_stk,
    output logic [OUT_WIDTH-1:0] o_dat,
    output logic                 o_sat
);
    localparam logic [MW-1:0] ONE     = {{(MW-1){1'b0}}, 1'b1};
    localparam logic [MW-1:0] NEG_LIM = ONE << (OUT_WIDTH - 1);
    localparam logic [MW-1:0] POS_LIM = NEG_LIM - ONE;

    logic                 w_up;
    logic [MW-1:0]        w_rnd;
    logic [OUT_WIDTH-1:0] w_neg;
    logic                 w_clip;

    assign w_up  = i_grd & (i_stk | i_mag[0]);
    assign w_rnd = i_mag + {{(MW-1){1'b0}}, w_up};
    assign w_neg = ~w_rnd[OUT_WIDTH-1:0] + {{(OUT_WIDTH-1){1'b0}}, 1'b1};

    // Negative side reaches one further: exactly -2^(W-1) is representable.
    assign w_clip = i_ovf || (i_sgn ? (w_rnd > NEG_LIM) : (w_rnd > POS_LIM));

    always_comb begin
        o_dat = '0;
        o_sat = 1'b0;
        if (!i_flush) begin
            if (w_clip) begin
                o_sat = 1'b1;
                o_dat = i_sgn ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end else begin
                o_dat = i_sgn ? w_neg : w_rnd[OUT_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/neural_stage_float2fix.sv
// float_24_8 -> signed fixed point (FRAC_BITS fractional), 2-cycle latency, one result per cycle.
// Single global enable: a stalled output freezes both stages and deasserts in_ready.
module neural_stage_float2fix
    import neural_stage_float2fix_pkg::*;
#(
    parameter int OUT_WIDTH = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    neural_stage_float2fix_if.slave bus,
    input  logic                    sat_clear,
    output logic [15:0]             sat_count
);
    localparam int MW = OUT_WIDTH + 25;

    float_24_8            w_op;
    logic                 w_en;
    logic [23:0]          w_sig;
    logic [10:0]          w_k;
    logic [10:0]          w_r;
    logic                 w_left;
    logic                 w_flush;
    logic                 w_ovf;
    logic [MW-1:0]        w_shl;
    logic [49:0]          w_ext;
    logic [MW-1:0]        w_mag;
    logic                 w_grd;
    logic                 w_stk;
    logic [OUT_WIDTH-1:0] w_rnd_dat;
    logic                 w_rnd_sat;

    logic                 r_s1_vld;
    logic                 r_s1_sgn;
    logic                 r_s1_flush;
    logic                 r_s1_ovf;
    logic [MW-1:0]        r_s1_mag;
    logic                 r_s1_grd;
    logic                 r_s1_stk;
    logic                 r_out_vld;
    logic [OUT_WIDTH-1:0] r_out_dat;
    logic                 r_out_sat;
    logic [15:0]          r_sat_cnt;

    assign w_op         = bus.in_data;
    assign w_en         = !r_out_vld || bus.out_ready;
    assign bus.in_ready = w_en;

    // k = exp - bias + FRAC_BITS - 23, kept as 11-bit two's complement.
    assign w_sig   = {1'b1, w_op.man};
    assign w_k     = {3'b000, w_op.exp} - {3'b000, EXP_BIAS} + 11'(FRAC_BITS - 23);
    assign w_r     = 11'd0 - w_k;
    assign w_left  = !w_k[10];
    assign w_flush = w_op.exp < FLUSH_EXP;
    assign w_ovf   = (w_op.exp == 8'hFF) || (w_left && (w_k > 11'(OUT_WIDTH)));
    assign w_shl   = {{(MW-24){1'b0}}, w_sig} << w_k;
    assign w_ext   = {w_sig, 26'b0} >> w_r;

    always_comb begin
        w_mag = '0;
        w_grd = 1'b0;
        w_stk = 1'b0;
        if (w_left) begin
            w_mag = w_shl;
        end else if (w_r <= 11'd25) begin
            w_mag = {{(MW-24){1'b0}}, w_ext[49:26]};
            w_grd = w_ext[25];
            w_stk = |w_ext[24:0];
        end
    end

    neural_stage_float2fix_round #(
        .OUT_WIDTH (OUT_WIDTH),
        .MW        (MW)
    ) u_round (
        .i_sgn   (r_s1_sgn),
        .i_flush (r_s1_flush),
        .i_ovf   (r_s1_ovf),
        .i_mag   (r_s1_mag),
        .i_grd   (r_s1_grd),
        .i_stk   (r_s1_stk),
        .o_dat   (w_rnd_dat),
        .o_sat   (w_rnd_sat)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1_sgn   <= 1'b0;
            r_s1_flush <= 1'b0;
            r_s1_ovf   <= 1'b0;
            r_s1_mag   <= '0;
            r_s1_grd   <= 1'b0;
            r_s1_stk   <= 1'b0;
            r_out_vld  <= 1'b0;
            r_out_dat  <= '0;
            r_out_sat  <= 1'b0;
        end else if (w_en) begin
            r_s1_vld   <= bus.in_valid;
            r_s1_sgn   <= w_op.sgn;
            r_s1_flush <= w_flush;
            r_s1_ovf   <= w_ovf;
            r_s1_mag   <= w_mag;
            r_s1_grd   <= w_grd;
            r_s1_stk   <= w_stk;
            r_out_vld  <= r_s1_vld;
            r_out_dat  <= w_rnd_dat;
            r_out_sat  <= w_rnd_sat;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sat_cnt <= 16'd0;
        end else if (sat_clear) begin
            r_sat_cnt <= 16'd0;
        end else if (r_out_vld && bus.out_ready && r_out_sat && (r_sat_cnt != 16'hFFFF)) begin
            r_sat_cnt <= r_sat_cnt + 16'd1;
        end
    end

    assign bus.out_valid = r_out_vld;
    assign bus.out_data  = r_out_dat;
    assign bus.out_sat   = r_out_sat;
    assign sat_count     = r_sat_cnt;
endmodule

// File: doc/neural_stage_float2fix.md
NEURAL_STAGE_FLOAT2FIX -- requirements
Module: neural_stage_float2fix

Interface
REQ-001 SHALL have parameter OUT_WIDTH, default 32, width of the signed fixed-point result.
REQ-002 SHALL have parameter FRAC_BITS, default 16, number of fractional bits in the result.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data is valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  float_24_8  operand (sgn, exp[7:0], man[22:0]), as produced by the stage adder.
REQ-008 SHALL have port out_valid  output  1  out_data/out_sat valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-010 SHALL have port out_data  output  OUT_WIDTH  signed two's-complement result, FRAC_BITS fractional bits.
REQ-011 SHALL have port out_sat  output  1  result was clamped.
REQ-012 SHALL have port sat_count  output  16  count of saturated results since reset/clear.
REQ-013 SHALL have port sat_clear  input  1  synchronous clear of sat_count.

Function
REQ-014 SHALL compute round(value * 2^FRAC_BITS), where value = (-1)^sgn * 1.man * 2^(exp-127).
REQ-015 SHALL treat exp < 10 as zero (flush): out_data = 0, out_sat = 0, independent of sgn/man.
REQ-016 SHALL treat exp = 255 as overflow: clamp by sign, out_sat = 1.
REQ-017 SHALL form shift k = exp - 127 + FRAC_BITS - 23 on the 24-bit significand {1,man}: left shift if k >= 0, right shift otherwise.
REQ-018 SHALL round right shifts to nearest, ties to even (guard = first dropped bit, sticky = OR of remaining bits, LSB tie-break); -k > 25 yields 0.
REQ-019 SHALL negate the rounded magnitude when sgn = 1.
REQ-020 SHALL clamp to 2^(OUT_WIDTH-1)-1 (positive) or -2^(OUT_WIDTH-1) (negative) when the result is out of range, and set out_sat = 1; an exact -2^(OUT_WIDTH-1) is not saturation.
REQ-021 SHALL be a 2-stage pipeline: stage 1 decode/shift, stage 2 round/negate/saturate and output register; latency 2 cycles from accepted input to out_valid.
REQ-022 SHALL use a global pipeline enable en = !out_valid || out_ready, with in_ready = en; a transfer occurs on in_valid && in_ready.
REQ-023 SHALL hold out_data/out_sat stable while out_valid && !out_ready; no input is lost or duplicated under backpressure.
REQ-024 SHALL sustain one result per cycle while out_ready = 1.
REQ-025 SHALL increment sat_count by 1 on each output transfer (out_valid && out_ready) with out_sat = 1, saturating at 16'hFFFF.
REQ-026 SHALL give sat_clear priority over a simultaneous increment (result 0).

Reset
REQ-027 SHALL on reset clear both stage valid bits, out_valid = 0, out_data = 0, out_sat = 0, sat_count = 0, immediately and asynchronously.
REQ-028 SHALL discard in-flight data on reset mid-operation; the first accepted input after release yields the first output.

Structure
REQ-029 SHALL take float_24_8 and the exponent bias (127) and flush threshold (10) from the shared types package.
REQ-030 SHALL implement rounding/saturation in one sub-module, neural_stage_float2fix_round; stage 1 lives in the top level.

Verification (OUT_WIDTH=32, FRAC_BITS=16)
REQ-031 exp=127,man=0,sgn=0 -> 0x00010000; sgn=1,exp=128 -> 0xFFFE0000 (-131072), sat=0, two cycles after acceptance.
REQ-032 exp=110,man=0 (0.5 LSB) -> 0; exp=110,man=0x400000 (0.75 LSB) -> 1; exp=111,man=0x400000 (1.5 LSB) -> 2.
REQ-033 exp=142,sgn=0 -> 0x7FFFFFFF, sat=1; exp=142,sgn=1,man=0 -> 0x80000000, sat=0; exp=255 -> clamp, sat=1; exp=9 -> 0, sat=0.
REQ-034 Stream 8 operands with out_ready toggled randomly -> outputs in order, none dropped/duplicated, data stable while stalled.
REQ-035 Three saturating outputs, then sat_clear asserted together with a fourth saturating transfer -> sat_count 3, then 0.
REQ-036 Assert reset with both stages full -> out_valid = 0 at once; after release, next input produces exactly one output after 2 cycles.
